// File: rtl/eth_xmii_rx_deser.sv
// eth_xmii_rx_deser: MII/RMII receive deserializer to an 8-bit AXI-Stream with frame status pulses.
// Defining ETH_XMII_RX_STATS_EN adds the saturating stat_good_frames/stat_bad_frames counters.
module eth_xmii_rx_deser #(
  parameter int PHY_W         = 4,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phy_clk_en,
  input  logic [PHY_W-1:0] phy_rxd,
  input  logic             phy_rx_dv,
  input  logic             phy_rx_er,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic             rx_start_packet,
  output logic             rx_error_bad_frame,
  output logic             rx_error_oversize
`ifdef ETH_XMII_RX_STATS_EN
  ,
  output logic [15:0]      stat_good_frames,
  output logic [15:0]      stat_bad_frames
`endif
);
  localparam int CW = $clog2(MAX_FRAME_LEN + 2);
  localparam logic [PHY_W-1:0] PRE = (PHY_W == 4) ? PHY_W'(4'h5) : PHY_W'(2'b01);
  localparam logic [PHY_W-1:0] SFD = (PHY_W == 4) ? PHY_W'(4'hD) : PHY_W'(2'b11);
  localparam logic [1:0] BEAT_LAST = 2'(8 / PHY_W - 1);

  if (!(PHY_W == 4 || PHY_W == 2)) begin : g_bad_phy_w
    $error("PHY_W must be 4 or 2");
  end

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t          r_state;
  logic [7:0]      r_shift;
  logic [1:0]      r_beat;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic            r_pend;
  logic [7:0]      r_pend_data;
  logic            r_sent;

  logic [7:0] w_byte;
  logic       w_last;
  logic       w_bad;

  assign w_byte = {phy_rxd, r_shift[7:PHY_W]};
  assign w_last = r_beat == BEAT_LAST;
  assign w_bad  = r_err | (r_beat != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= IDLE;
      r_shift            <= '0;
      r_beat             <= '0;
      r_cnt              <= '0;
      r_err              <= 1'b0;
      r_pend             <= 1'b0;
      r_pend_data        <= '0;
      r_sent             <= 1'b0;
      m_axis_tdata       <= '0;
      m_axis_tvalid      <= 1'b0;
      m_axis_tlast       <= 1'b0;
      m_axis_tuser       <= 1'b0;
      rx_start_packet    <= 1'b0;
      rx_error_bad_frame <= 1'b0;
      rx_error_oversize  <= 1'b0;
    end else begin
      m_axis_tvalid      <= 1'b0;
      m_axis_tlast       <= 1'b0;
      m_axis_tuser       <= 1'b0;
      rx_start_packet    <= 1'b0;
      rx_error_bad_frame <= 1'b0;
      rx_error_oversize  <= 1'b0;
      if (phy_clk_en) begin
        case (r_state)
          // IDLE treats its first valid sample exactly like a preamble sample
          IDLE, PREAMBLE: begin
            if (!phy_rx_dv) r_state <= IDLE;
            else if (phy_rxd == PRE) r_state <= PREAMBLE;
            else if (phy_rxd == SFD) begin
              r_state <= DATA;
              r_shift <= '0;
              r_beat  <= '0;
              r_cnt   <= '0;
              r_err   <= 1'b0;
              r_pend  <= 1'b0;
              r_sent  <= 1'b0;
            end else begin
              r_state            <= DROP;
              rx_error_bad_frame <= 1'b1;
            end
          end
          DATA: begin
            if (phy_rx_dv) begin
              r_shift <= w_byte;
              r_err   <= r_err | phy_rx_er;
              r_beat  <= w_last ? 2'd0 : r_beat + 2'd1;
              if (w_last) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_pend) begin
                  m_axis_tvalid   <= 1'b1;
                  m_axis_tdata    <= r_pend_data;
                  rx_start_packet <= !r_sent;
                  r_sent          <= 1'b1;
                end
                // the byte that would exceed the limit is discarded, the held one closes the frame
                if (r_cnt == CW'(MAX_FRAME_LEN)) begin
                  m_axis_tlast       <= r_pend;
                  m_axis_tuser       <= r_pend;
                  rx_error_oversize  <= 1'b1;
                  rx_error_bad_frame <= 1'b1;
                  r_pend             <= 1'b0;
                  r_state            <= DROP;
                end else begin
                  r_pend      <= 1'b1;
                  r_pend_data <= w_byte;
                end
              end
            end else begin
              r_state <= IDLE;
              r_pend  <= 1'b0;
              if (r_pend) begin
                m_axis_tvalid      <= 1'b1;
                m_axis_tdata       <= r_pend_data;
                m_axis_tlast       <= 1'b1;
                m_axis_tuser       <= w_bad;
                rx_error_bad_frame <= w_bad;
                rx_start_packet    <= !r_sent;
                r_sent             <= 1'b1;
              end else begin
                rx_error_bad_frame <= 1'b1;
              end
            end
          end
          default: if (!phy_rx_dv) r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef ETH_XMII_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_good_frames <= '0;
      stat_bad_frames  <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tlast && !m_axis_tuser && stat_good_frames != 16'hFFFF)
        stat_good_frames <= stat_good_frames + 16'd1;
      if (rx_error_bad_frame && stat_bad_frames != 16'hFFFF)
        stat_bad_frames <= stat_bad_frames + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_eth_xmii_rx_deser.sv
// tb_eth_xmii_rx_deser: directed checks of the MII/RMII deserializer with hand-computed beats.
module tb_eth_xmii_rx_deser;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] rxd4 = '0;
  logic       dv4 = 1'b0, er4 = 1'b0;
  logic [1:0] rxd2 = '0;
  logic       dv2 = 1'b0, en2 = 1'b0;
  int         c10 = 0;

  logic [7:0] td4, tdm, td2;
  logic tv4, tl4, tu4, st4, be4, ov4;
  logic tvm, tlm, tum, stm, bem, ovm;
  logic tv2, tl2, tu2, st2, be2, ov2;

  eth_xmii_rx_deser #(.PHY_W(4), .MAX_FRAME_LEN(1518)) d4 (
    .clk(clk), .rst_n(rst_n), .phy_clk_en(1'b1), .phy_rxd(rxd4), .phy_rx_dv(dv4), .phy_rx_er(er4),
    .m_axis_tdata(td4), .m_axis_tvalid(tv4), .m_axis_tlast(tl4), .m_axis_tuser(tu4),
    .rx_start_packet(st4), .rx_error_bad_frame(be4), .rx_error_oversize(ov4));

  eth_xmii_rx_deser #(.PHY_W(4), .MAX_FRAME_LEN(4)) dm (
    .clk(clk), .rst_n(rst_n), .phy_clk_en(1'b1), .phy_rxd(rxd4), .phy_rx_dv(dv4), .phy_rx_er(er4),
    .m_axis_tdata(tdm), .m_axis_tvalid(tvm), .m_axis_tlast(tlm), .m_axis_tuser(tum),
    .rx_start_packet(stm), .rx_error_bad_frame(bem), .rx_error_oversize(ovm));

  eth_xmii_rx_deser #(.PHY_W(2), .MAX_FRAME_LEN(1518)) d2 (
    .clk(clk), .rst_n(rst_n), .phy_clk_en(en2), .phy_rxd(rxd2), .phy_rx_dv(dv2), .phy_rx_er(1'b0),
    .m_axis_tdata(td2), .m_axis_tvalid(tv2), .m_axis_tlast(tl2), .m_axis_tuser(tu2),
    .rx_start_packet(st2), .rx_error_bad_frame(be2), .rx_error_oversize(ov2));

  always @(negedge clk) begin
    c10 = (c10 == 9) ? 0 : c10 + 1;
    en2 = (c10 == 0);
  end

  // {tlast, tuser, tdata} per beat, plus pulse counts, sampled away from the active edge
  logic [9:0] q4[$], qm[$], q2[$];
  int s4, sm, s2, b4, bm, b2, o4, om;
  always @(negedge clk) begin
    if (tv4) q4.push_back({tl4, tu4, td4});
    if (tvm) qm.push_back({tlm, tum, tdm});
    if (tv2) q2.push_back({tl2, tu2, td2});
    s4 += int'(st4); sm += int'(stm); s2 += int'(st2);
    b4 += int'(be4); bm += int'(bem); b2 += int'(be2);
    o4 += int'(ov4); om += int'(ovm);
  end

  int n_checks = 0, n_errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    q4.delete(); qm.delete(); q2.delete();
    s4 = 0; sm = 0; s2 = 0; b4 = 0; bm = 0; b2 = 0; o4 = 0; om = 0;
  endtask

  task automatic s4x(input logic [3:0] d, input logic dv, input logic er = 1'b0);
    rxd4 = d; dv4 = dv; er4 = er;
    @(posedge clk); #1;
  endtask
  task automatic byte4(input logic [7:0] b, input logic er_lo = 1'b0);
    s4x(b[3:0], 1'b1, er_lo);
    s4x(b[7:4], 1'b1);
  endtask
  task automatic pre4();
    repeat (15) s4x(4'h5, 1'b1);
    s4x(4'hD, 1'b1);
  endtask
  task automatic idle4(input int n);
    repeat (n) s4x(4'h0, 1'b0);
  endtask

  task automatic s2x(input logic [1:0] d, input logic dv);
    int guard;
    rxd2 = d; dv2 = dv; guard = 0;
    do begin @(posedge clk); guard++; end while (!en2 && guard < 20);
    if (!en2) check("s2_enable_timeout", en2, 1);
    #1;
  endtask

  initial begin
    clr();
    #2 rst_n = 1'b0;
    #1;
    check("rst.tvalid4", tv4, 0);
    check("rst.tdata4", td4, 0);
    check("rst.tlast4", tl4, 0);
    check("rst.start4", st4, 0);
    check("rst.bad4", be4, 0);
    check("rst.tvalid2", tv2, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle4(2);

    // three-byte good frame
    clr(); pre4(); byte4(8'h12); byte4(8'h34); byte4(8'h56); idle4(3);
    check("A.n", q4.size(), 3);
    check("A.b0", q4[0], 10'h012);
    check("A.b1", q4[1], 10'h034);
    check("A.b2", q4[2], 10'h256);
    check("A.start", s4, 1);
    check("A.bad", b4, 0);
    check("A.dm_n", qm.size(), 3);

    // receive error on a nibble of the first byte
    clr(); pre4(); byte4(8'h01, 1'b1); byte4(8'h02); idle4(3);
    check("C.n", q4.size(), 2);
    check("C.b0", q4[0], 10'h001);
    check("C.b1", q4[1], 10'h302);
    check("C.bad", b4, 1);

    // trailing odd nibble
    clr(); pre4(); byte4(8'hAA); byte4(8'hBB); s4x(4'h7, 1'b1); idle4(3);
    check("D.n", q4.size(), 2);
    check("D.b0", q4[0], 10'h0AA);
    check("D.b1", q4[1], 10'h3BB);
    check("D.bad", b4, 1);

    // dv falls right after SFD
    clr(); pre4(); idle4(3);
    check("Z.n", q4.size(), 0);
    check("Z.bad", b4, 1);
    check("Z.start", s4, 0);

    // oversize on the MAX_FRAME_LEN=4 instance
    clr(); pre4();
    for (int i = 0; i < 6; i++) byte4(8'(i));
    idle4(3);
    check("E.n", qm.size(), 4);
    check("E.b0", qm[0], 10'h000);
    check("E.b2", qm[2], 10'h002);
    check("E.b3", qm[3], 10'h303);
    check("E.over", om, 1);
    check("E.bad", bm, 1);
    check("E.start", sm, 1);
    check("E.d4_n", q4.size(), 6);
    check("E.d4_last", q4[5], 10'h205);
    check("E.d4_over", o4, 0);
    clr(); pre4(); byte4(8'h77); idle4(3);
    check("E.next_n", qm.size(), 1);
    check("E.next_b0", qm[0], 10'h277);

    // reset asserted while a beat is on the bus
    clr(); pre4(); byte4(8'h11); byte4(8'h22);
    check("F.pre_valid", tv4, 1);
    check("F.pre_data", td4, 8'h11);
    rst_n = 1'b0; rxd4 = 4'h3; dv4 = 1'b1;
    #1;
    check("F.rst_valid", tv4, 0);
    check("F.rst_data", td4, 0);
    @(posedge clk); #1;
    clr(); rst_n = 1'b1;
    s4x(4'h3, 1'b1); s4x(4'h5, 1'b1); s4x(4'hD, 1'b1); byte4(8'h33); idle4(3);
    check("F.n", q4.size(), 0);
    check("F.bad", b4, 1);
    check("F.start", s4, 0);

    // RMII with enable every tenth clock
    clr();
    repeat (31) s2x(2'b01, 1'b1);
    s2x(2'b11, 1'b1);
    s2x(2'b01, 1'b1); s2x(2'b01, 1'b1); s2x(2'b10, 1'b1); s2x(2'b10, 1'b1);
    s2x(2'b00, 1'b0); s2x(2'b00, 1'b0);
    check("G.n", q2.size(), 1);
    check("G.b0", q2[0], 10'h2A5);
    check("G.start", s2, 1);
    check("G.bad", b2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
